tanque_sim: RTL and testbench

Tank-plant emulator: the sensor-side counterpart of the pump controller. Consumes the pump command and a consumption (drain) enable. Integrates a water level in a saturating counter and drives the three thermometer-coded level sensors the controller reads, plus overflow/empty status. Used on the board's IO bank or in closed-loop benches so the pump controller can run without a physical tank.

---
 rtl/tanque_sim_if.sv | 34 +++
 rtl/tanque_sim.sv | 113 +++++++++++
 tb/tb_tanque_sim.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tanque_sim_if.sv
// Tank emulator handshake bundle: pump/drain commands in, sensor and status out.
// Optional SENSOR_FALLA_EN adds the stuck-at injection controls.
interface tanque_sim_if #(
  parameter int LEVEL_W = 8
);
  logic               bomba_i;
  logic               consumo_i;
  logic               clr_i;
  logic [2:0]         sensores_o;
  logic [LEVEL_W-1:0] nivel_o;
  logic               desborde_o;
  logic               vacio_o;
  logic [1:0]         estado_o;
`ifdef SENSOR_FALLA_EN
  logic [2:0]         falla_i;
  logic [2:0]         falla_val_i;
`endif

  modport master (
    output bomba_i, consumo_i, clr_i,
`ifdef SENSOR_FALLA_EN
    output falla_i, falla_val_i,
`endif
    input  sensores_o, nivel_o, desborde_o, vacio_o, estado_o
  );

  modport slave (
    input  bomba_i, consumo_i, clr_i,
`ifdef SENSOR_FALLA_EN
    input  falla_i, falla_val_i,
`endif
    output sensores_o, nivel_o, desborde_o, vacio_o, estado_o
  );
endinterface

// File: rtl/tanque_sim.sv
// Tank-plant emulator: integrates pump/drain into a saturating level and drives
// thermometer sensors plus overflow/empty status. Optional macro: SENSOR_FALLA_EN.
module tanque_sim #(
  parameter int LEVEL_W    = 8,
  parameter int FILL_DIV   = 4,
  parameter int DRAIN_DIV  = 8,
  parameter int TH_LO      = 32,
  parameter int TH_MID     = 128,
  parameter int TH_HI      = 224,
  parameter int LEVEL_INIT = 0
) (
  input logic         ck,
  input logic         rst_i,
  tanque_sim_if.slave bus
);
  localparam int FW = (FILL_DIV  > 1) ? $clog2(FILL_DIV)  : 1;
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [FW-1:0]      FILL_LAST  = FW'(FILL_DIV - 1);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(DRAIN_DIV - 1);
  localparam logic [LEVEL_W-1:0] LVL_INIT   = LEVEL_W'(LEVEL_INIT);
  localparam logic [LEVEL_W-1:0] LVL_TH_LO  = LEVEL_W'(TH_LO);
  localparam logic [LEVEL_W-1:0] LVL_TH_MID = LEVEL_W'(TH_MID);
  localparam logic [LEVEL_W-1:0] LVL_TH_HI  = LEVEL_W'(TH_HI);

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    LLENANDO   = 2'd1,
    VACIANDO   = 2'd2,
    EQUILIBRIO = 2'd3
  } estado_t;

  estado_t            estado, estado_next;
  logic [FW-1:0]      fill_cnt;
  logic [DW-1:0]      drain_cnt;
  logic               fill_tick, drain_tick;
  logic [LEVEL_W-1:0] nivel, nivel_next;
  logic               desborde, desborde_next;
  logic [2:0]         sensores, sensores_next;
  logic               vacio;

  function automatic logic [2:0] termometro(input logic [LEVEL_W-1:0] l);
    return {l >= LVL_TH_HI, l >= LVL_TH_MID, l >= LVL_TH_LO};
  endfunction

  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) estado <= REPOSO;
    else       estado <= estado_next;
  end

  always_comb begin
    estado_next = REPOSO;
    unique case ({bus.consumo_i, bus.bomba_i})
      2'b01:   estado_next = LLENANDO;
      2'b10:   estado_next = VACIANDO;
      2'b11:   estado_next = EQUILIBRIO;
      default: estado_next = REPOSO;
    endcase
  end

  assign fill_tick  = bus.bomba_i   && (fill_cnt  == FILL_LAST);
  assign drain_tick = bus.consumo_i && (drain_cnt == DRAIN_LAST);

  // Coincident fill and drain ticks cancel; saturation at either end holds the level.
  always_comb begin
    nivel_next    = nivel;
    desborde_next = bus.clr_i ? 1'b0 : desborde;
    if (fill_tick && !drain_tick) begin
      if (nivel == '1) desborde_next = 1'b1;
      else             nivel_next    = nivel + 1'b1;
    end else if (drain_tick && !fill_tick && nivel != '0) begin
      nivel_next = nivel - 1'b1;
    end
  end

  always_comb begin
    sensores_next = termometro(nivel_next);
`ifdef SENSOR_FALLA_EN
    sensores_next = (sensores_next & ~bus.falla_i) | (bus.falla_val_i & bus.falla_i);
`endif
  end

  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      fill_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (!bus.bomba_i || fill_tick) fill_cnt  <= '0;
      else                           fill_cnt  <= fill_cnt + 1'b1;
      if (!bus.consumo_i || drain_tick) drain_cnt <= '0;
      else                              drain_cnt <= drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge ck or posedge rst_i) begin
    if (rst_i) begin
      nivel    <= LVL_INIT;
      desborde <= 1'b0;
      sensores <= termometro(LVL_INIT);
      vacio    <= (LVL_INIT == '0);
    end else begin
      nivel    <= nivel_next;
      desborde <= desborde_next;
      sensores <= sensores_next;
      vacio    <= (nivel_next == '0);
    end
  end

  assign bus.nivel_o    = nivel;
  assign bus.desborde_o = desborde;
  assign bus.sensores_o = sensores;
  assign bus.vacio_o    = vacio;
  assign bus.estado_o   = estado;
endmodule

// File: tb/tb_tanque_sim.sv
// Self-checking bench for tanque_sim: vector table with expected-value scoreboard
// plus hand sequences for async reset, equilibrium divisors and sensor faults.
module tb_tanque_sim;
  logic ck = 1'b0;
  logic rst_i;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 ck = ~ck;

  tanque_sim_if #(.LEVEL_W(8)) bus ();
  tanque_sim_if #(.LEVEL_W(8)) bus2 ();

  tanque_sim #(.LEVEL_W(8)) dut (.ck(ck), .rst_i(rst_i), .bus(bus.slave));
  tanque_sim #(.LEVEL_W(8), .FILL_DIV(4), .DRAIN_DIV(4), .LEVEL_INIT(100))
    dut2 (.ck(ck), .rst_i(rst_i), .bus(bus2.slave));

  typedef struct {
    logic        b, c, clr;
    int unsigned n;
    logic [7:0]  lvl;
    logic [2:0]  sens;
    logic        vac, des;
  } vec_t;

  typedef struct {
    logic [7:0] lvl;
    logic [2:0] sens;
    logic       vac, des;
    logic [1:0] est;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input exp_t e);
    chk({nm, ".nivel"},    32'(bus.nivel_o),    32'(e.lvl));
    chk({nm, ".sensores"}, 32'(bus.sensores_o), 32'(e.sens));
    chk({nm, ".vacio"},    32'(bus.vacio_o),    32'(e.vac));
    chk({nm, ".desborde"}, 32'(bus.desborde_o), 32'(e.des));
    chk({nm, ".estado"},   32'(bus.estado_o),   32'(e.est));
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    bus.bomba_i   = v.b;
    bus.consumo_i = v.c;
    bus.clr_i     = v.clr;
    // state encoding: 0 idle, 1 filling, 2 draining, 3 both
    e = '{lvl: v.lvl, sens: v.sens, vac: v.vac, des: v.des, est: {v.c, v.b}};
    sb.push_back(e);
    repeat (v.n) @(posedge ck);
    @(negedge ck);
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      chk_dut($sformatf("vec%0d", idx), e);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.bomba_i = 0; bus.consumo_i = 0; bus.clr_i = 0;
    bus2.bomba_i = 0; bus2.consumo_i = 0; bus2.clr_i = 0;
`ifdef SENSOR_FALLA_EN
    bus.falla_i = '0;  bus.falla_val_i = '0;
    bus2.falla_i = '0; bus2.falla_val_i = '0;
`endif
    //        b  c  clr n     lvl  sens    vac des
    tbl.push_back('{0, 0, 0, 3,    8'd0,   3'b000, 1, 0});
    tbl.push_back('{1, 0, 0, 4,    8'd1,   3'b000, 0, 0});
    tbl.push_back('{1, 0, 0, 124,  8'd32,  3'b001, 0, 0});
    tbl.push_back('{1, 0, 0, 384,  8'd128, 3'b011, 0, 0});
    tbl.push_back('{1, 0, 0, 384,  8'd224, 3'b111, 0, 0});
    tbl.push_back('{1, 0, 0, 124,  8'd255, 3'b111, 0, 0});
    tbl.push_back('{1, 0, 0, 4,    8'd255, 3'b111, 0, 1});
    tbl.push_back('{0, 0, 1, 1,    8'd255, 3'b111, 0, 0});
    tbl.push_back('{1, 0, 0, 3,    8'd255, 3'b111, 0, 0});
    tbl.push_back('{1, 0, 1, 1,    8'd255, 3'b111, 0, 1});
    tbl.push_back('{0, 1, 0, 1776, 8'd33,  3'b001, 0, 1});
    tbl.push_back('{0, 1, 0, 8,    8'd32,  3'b001, 0, 1});
    tbl.push_back('{0, 1, 0, 8,    8'd31,  3'b000, 0, 1});
    tbl.push_back('{0, 1, 0, 248,  8'd0,   3'b000, 1, 1});
    tbl.push_back('{0, 1, 0, 16,   8'd0,   3'b000, 1, 1});
    tbl.push_back('{0, 0, 1, 1,    8'd0,   3'b000, 1, 0});
    tbl.push_back('{1, 1, 0, 8,    8'd1,   3'b000, 0, 0});

    repeat (2) @(posedge ck);
    #1;
    chk_dut("reset", '{lvl: 8'd0, sens: 3'b000, vac: 1'b1, des: 1'b0, est: 2'd0});
    chk("reset2.nivel",    32'(bus2.nivel_o),    32'd100);
    chk("reset2.sensores", 32'(bus2.sensores_o), 32'b001);
    chk("reset2.vacio",    32'(bus2.vacio_o),    32'd0);
    @(negedge ck);
    rst_i = 1'b0;

    // Async reset mid-count: partial prescale must be discarded.
    bus.bomba_i = 1'b1;
    repeat (10) @(posedge ck);
    #1 chk("pre_rst.nivel", 32'(bus.nivel_o), 32'd2);
    #1 rst_i = 1'b1;
    #1;
    chk("async_rst.nivel",    32'(bus.nivel_o),    32'd0);
    chk("async_rst.vacio",    32'(bus.vacio_o),    32'd1);
    chk("async_rst.sensores", 32'(bus.sensores_o), 32'b000);
    @(negedge ck);
    rst_i = 1'b0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    chk("post_rst3.nivel", 32'(bus.nivel_o), 32'd0);
    @(posedge ck); @(negedge ck);
    chk("post_rst4.nivel", 32'(bus.nivel_o), 32'd1);
    bus.bomba_i = 1'b0;
    rst_i = 1'b1;
    @(negedge ck);
    rst_i = 1'b0;

    foreach (tbl[i]) apply(i, tbl[i]);
    bus.bomba_i = 0; bus.consumo_i = 0; bus.clr_i = 0;

    // Equal divisors: fill and drain ticks always coincide.
    bus2.bomba_i = 1'b1; bus2.consumo_i = 1'b1;
    repeat (40) @(posedge ck);
    @(negedge ck);
    chk("eq.nivel",  32'(bus2.nivel_o),  32'd100);
    chk("eq.estado", 32'(bus2.estado_o), 32'd3);
    bus2.bomba_i = 1'b0; bus2.consumo_i = 1'b0;

`ifdef SENSOR_FALLA_EN
    bus.falla_i = 3'b100; bus.falla_val_i = 3'b100;
    @(posedge ck); @(negedge ck);
    chk("falla.sensores", 32'(bus.sensores_o), 32'b100);
    chk("falla.nivel",    32'(bus.nivel_o),    32'd1);
    bus.falla_i = 3'b000;
    @(posedge ck); @(negedge ck);
    chk("falla_clr.sensores", 32'(bus.sensores_o), 32'b000);
`endif

    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
